// File: rtl/clock_time_counter_if.sv
// ---------------------------------------------------------------------------
// clock_time_counter_if
//  Bundles the event inputs and the time/mode outputs of the time-of-day core.
//  The core attaches through the slave modport; whatever feeds it events and
//  watches the display fields (prescaler, buttons, display mux, bench) uses master.
//
//  tick_min   one-cycle pulse per minute from the prescaler
//  btn_mode   one-cycle debounced pulse: advance set mode
//  btn_inc    one-cycle debounced pulse: increment the selected field
//  hh_tens    hours tens digit, BCD 0..2
//  hh_ones    hours ones digit, BCD 0..9 (0..3 when hh_tens==2)
//  mm_tens    minutes tens digit, BCD 0..5
//  mm_ones    minutes ones digit, BCD 0..9
//  mode       00=RUN, 01=SET_HH, 10=SET_MM
//  start      prescaler start, high only in RUN
//  day_tick   one-cycle pulse on the 23:59 -> 00:00 rollover in RUN
// ---------------------------------------------------------------------------
interface clock_time_counter_if;
  logic       tick_min;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] hh_tens;
  logic [3:0] hh_ones;
  logic [3:0] mm_tens;
  logic [3:0] mm_ones;
  logic [1:0] mode;
  logic       start;
  logic       day_tick;

  modport master (
    output tick_min, btn_mode, btn_inc,
    input  hh_tens, hh_ones, mm_tens, mm_ones, mode, start, day_tick
  );

  modport slave (
    input  tick_min, btn_mode, btn_inc,
    output hh_tens, hh_ones, mm_tens, mm_ones, mode, start, day_tick
  );
endinterface

// File: rtl/clock_time_counter.sv
// ---------------------------------------------------------------------------
// clock_time_counter
//  Time-of-day core of the digital clock. Counts the prescaler's minute pulse
//  into HH:MM (24-hour, BCD digits) and owns the set-time state machine driven
//  by the mode/increment buttons. While a field is being set, start is held low
//  so the prescaler restarts its minute phase when the clock returns to RUN.
//
//  Parameters
//   INIT_HOURS    binary hour loaded at reset, 0..23
//   INIT_MINUTES  binary minute loaded at reset, 0..59
//
//  Ports
//   clk   system clock, all state on posedge
//   rst   asynchronous, active-high reset (back to INIT time and RUN)
//   bus   clock_time_counter_if.slave: tick_min/btn_mode/btn_inc in;
//         hh_tens/hh_ones/mm_tens/mm_ones/mode/start/day_tick out
// ---------------------------------------------------------------------------
module clock_time_counter #(
  parameter int INIT_HOURS   = 0,
  parameter int INIT_MINUTES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_time_counter_if.slave  bus
);

  generate
    if (INIT_HOURS < 0 || INIT_HOURS > 23) begin : g_bad_init_hours
      $error("clock_time_counter: INIT_HOURS must be 0..23");
    end
    if (INIT_MINUTES < 0 || INIT_MINUTES > 59) begin : g_bad_init_minutes
      $error("clock_time_counter: INIT_MINUTES must be 0..59");
    end
  endgenerate

  localparam logic [3:0] INIT_HH_T = 4'(INIT_HOURS / 10);
  localparam logic [3:0] INIT_HH_O = 4'(INIT_HOURS % 10);
  localparam logic [3:0] INIT_MM_T = 4'(INIT_MINUTES / 10);
  localparam logic [3:0] INIT_MM_O = 4'(INIT_MINUTES % 10);

  // Encodings double as the external mode code.
  typedef enum logic [1:0] {
    RUN    = 2'b00,
    SET_HH = 2'b01,
    SET_MM = 2'b10
  } state_t;

  state_t     state;
  logic [3:0] hh_t, hh_o, mm_t, mm_o;
  logic       day_tick_q;

  // Single BCD digit increment: returns {carry, next_digit}; wraps to 0 at top.
  function automatic logic [4:0] bcd_digit_inc(input logic [3:0] d,
                                               input logic [3:0] top);
    logic [4:0] r;
    if (d >= top) r = 5'b1_0000;
    else          r = {1'b0, d + 4'd1};
    return r;
  endfunction

  // Minutes 00..59: returns {wrap, tens, ones}. Wrap is the carry into hours.
  function automatic logic [8:0] minute_inc(input logic [3:0] tens,
                                            input logic [3:0] ones);
    logic [4:0] o;
    logic [4:0] t;
    o = bcd_digit_inc(ones, 4'd9);
    t = o[4] ? bcd_digit_inc(tens, 4'd5) : {1'b0, tens};
    return {t[4], t[3:0], o[3:0]};
  endfunction

  // Hours 00..23: returns {wrap, tens, ones}. The ones digit only reaches 9
  // below 20, so tens never needs its own wrap check; 23 is the only rollover.
  function automatic logic [8:0] hour_inc(input logic [3:0] tens,
                                          input logic [3:0] ones);
    logic [4:0] o;
    logic [3:0] t;
    if (tens == 4'd2 && ones == 4'd3) begin
      return {1'b1, 4'd0, 4'd0};
    end
    o = bcd_digit_inc(ones, 4'd9);
    t = o[4] ? tens + 4'd1 : tens;
    return {1'b0, t, o[3:0]};
  endfunction

  logic [8:0] min_next;
  logic [8:0] hr_next;

  always_comb begin
    min_next = minute_inc(mm_t, mm_o);
    hr_next  = hour_inc(hh_t, hh_o);
  end

  // State, time digits and day_tick all update on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      hh_t       <= INIT_HH_T;
      hh_o       <= INIT_HH_O;
      mm_t       <= INIT_MM_T;
      mm_o       <= INIT_MM_O;
      day_tick_q <= 1'b0;
    end else begin
      day_tick_q <= 1'b0;
      case (state)
        RUN: begin
          // A minute tick coinciding with btn_mode is still counted.
          if (bus.tick_min) begin
            mm_t <= min_next[7:4];
            mm_o <= min_next[3:0];
            if (min_next[8]) begin
              hh_t <= hr_next[7:4];
              hh_o <= hr_next[3:0];
              day_tick_q <= hr_next[8];
            end
          end
          if (bus.btn_mode) state <= SET_HH;
        end
        SET_HH: begin
          if (bus.btn_mode) begin
            state <= SET_MM;
          end else if (bus.btn_inc) begin
            hh_t <= hr_next[7:4];
            hh_o <= hr_next[3:0];
          end
        end
        SET_MM: begin
          if (bus.btn_mode) begin
            state <= RUN;
          end else if (bus.btn_inc) begin
            mm_t <= min_next[7:4];
            mm_o <= min_next[3:0];
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.hh_tens  = hh_t;
  assign bus.hh_ones  = hh_o;
  assign bus.mm_tens  = mm_t;
  assign bus.mm_ones  = mm_o;
  assign bus.mode     = state;
  assign bus.start    = (state == RUN);
  assign bus.day_tick = day_tick_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// ---------------------------------------------------------------------------
// tb_clock_time_counter
//  Directed bench for clock_time_counter (INIT 00:00). Inputs are driven on the
//  falling edge, outputs are sampled 1 ns after the rising edge. Time is compared
//  as a 16-bit word {hh_tens, hh_ones, mm_tens, mm_ones}, e.g. 16'h2359.
// ---------------------------------------------------------------------------
module tb_clock_time_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  clock_time_counter_if bus ();

  clock_time_counter #(
    .INIT_HOURS   (0),
    .INIT_MINUTES (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] now();
    return {bus.hh_tens, bus.hh_ones, bus.mm_tens, bus.mm_ones};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; returns 1 ns after the capturing edge.
  task automatic step(input logic t, input logic m, input logic i);
    @(negedge clk);
    bus.tick_min = t;
    bus.btn_mode = m;
    bus.btn_inc  = i;
    @(posedge clk);
    #1;
    bus.tick_min = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  task automatic steps(input int n, input logic t, input logic m, input logic i);
    for (int k = 0; k < n; k++) step(t, m, i);
  endtask

  initial begin
    bus.tick_min = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;

    // 1: reset state
    #2 rst = 1'b1;
    #1;
    check("rst_time",     32'(now()),        32'h0000);
    check("rst_mode",     32'(bus.mode),     32'd0);
    check("rst_start",    32'(bus.start),    32'd1);
    check("rst_day_tick", 32'(bus.day_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 2: running minute/hour carries
    steps(59, 1'b1, 1'b0, 1'b0);
    check("run_0059", 32'(now()), 32'h0059);
    step(1'b1, 1'b0, 1'b0);
    check("run_0100", 32'(now()), 32'h0100);
    steps(539, 1'b1, 1'b0, 1'b0);
    check("run_0959", 32'(now()), 32'h0959);
    step(1'b1, 1'b0, 1'b0);
    check("run_1000", 32'(now()), 32'h1000);
    step(1'b0, 1'b0, 1'b1);
    check("run_inc_ignored", 32'(now()), 32'h1000);

    // 3: set 23:59, then day rollover in RUN
    step(1'b0, 1'b1, 1'b0);
    check("seth_mode",  32'(bus.mode),  32'd1);
    check("seth_start", 32'(bus.start), 32'd0);
    steps(13, 1'b0, 1'b0, 1'b1);
    check("seth_23", 32'(now()), 32'h2300);
    step(1'b0, 1'b1, 1'b0);
    steps(59, 1'b0, 1'b0, 1'b1);
    check("setm_2359", 32'(now()), 32'h2359);
    step(1'b0, 1'b1, 1'b0);
    check("back_run_mode",  32'(bus.mode),  32'd0);
    check("back_run_start", 32'(bus.start), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    check("rollover_time",     32'(now()),        32'h0000);
    check("rollover_day_tick", 32'(bus.day_tick), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("day_tick_one_cycle", 32'(bus.day_tick), 32'd0);
    check("after_rollover",     32'(now()),        32'h0000);

    // 4: SET_HH wrap, ticks ignored, SET_MM wrap without carry
    step(1'b0, 1'b1, 1'b0);
    check("s4_mode_hh",  32'(bus.mode),  32'd1);
    check("s4_start_hh", 32'(bus.start), 32'd0);
    steps(25, 1'b0, 1'b0, 1'b1);
    check("s4_hh_wrap", 32'(now()), 32'h0100);
    steps(5, 1'b1, 1'b0, 1'b0);
    check("s4_tick_ignored", 32'(now()), 32'h0100);
    step(1'b0, 1'b1, 1'b0);
    check("s4_mode_mm", 32'(bus.mode), 32'd2);
    steps(59, 1'b0, 1'b0, 1'b1);
    check("s4_mm_59", 32'(now()), 32'h0159);
    step(1'b0, 1'b0, 1'b1);
    check("s4_mm_wrap",     32'(now()),        32'h0100);
    check("s4_no_day_tick", 32'(bus.day_tick), 32'd0);

    // 5: simultaneous events
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    steps(4, 1'b0, 1'b0, 1'b1);
    check("s5_hh_05", 32'(now()), 32'h0500);
    step(1'b0, 1'b1, 1'b1);
    check("s5_mode_inc_mode", 32'(bus.mode), 32'd2);
    check("s5_mode_inc_time", 32'(now()),    32'h0500);
    step(1'b0, 1'b1, 1'b0);
    check("s5_run", 32'(bus.mode), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    steps(9, 1'b1, 1'b0, 1'b0);
    check("s5_0009", 32'(now()), 32'h0009);
    step(1'b1, 1'b1, 1'b0);
    check("s5_mode_tick_time", 32'(now()),     32'h0010);
    check("s5_mode_tick_mode", 32'(bus.mode),  32'd1);
    check("s5_mode_tick_start", 32'(bus.start), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("s5_setmm_tick_mode", 32'(bus.mode), 32'd0);
    check("s5_setmm_tick_time", 32'(now()),    32'h0010);

    // 6: asynchronous reset from SET_MM at 12:34
    step(1'b0, 1'b1, 1'b0);
    steps(12, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    steps(24, 1'b0, 1'b0, 1'b1);
    check("s6_1234",    32'(now()),    32'h1234);
    check("s6_mode_mm", 32'(bus.mode), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("s6_async_time",  32'(now()),     32'h0000);
    check("s6_async_mode",  32'(bus.mode),  32'd0);
    check("s6_async_start", 32'(bus.start), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Reset clears a pending day_tick
    step(1'b0, 1'b1, 1'b0);
    steps(23, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    steps(59, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("dt_2359", 32'(now()), 32'h2359);
    step(1'b1, 1'b0, 1'b0);
    check("dt_pending", 32'(bus.day_tick), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("dt_cleared", 32'(bus.day_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
